// File: rtl/memshare_sched_mc.sv
// memshare_sched_mc: round-robin scheduler that walks L1PA shift-pattern chains per share group
// and streams shift controls downstream under valid/ready.
module memshare_sched_mc #(
    parameter int NUM_CH           = 4,
    parameter int SHARE_GROUP_SIZE = 6,
    parameter int DELTA_W          = 4,
    parameter int MAX_SEQ          = 8,
    parameter int SHIFT_W          = $clog2(SHARE_GROUP_SIZE),
    parameter int PAGE_W           = SHIFT_W + DELTA_W + 1,
    parameter int PAGE_NUM         = 2 ** SHARE_GROUP_SIZE,
    parameter int CH_W             = $clog2(NUM_CH),
    parameter int SEQ_W            = $clog2(MAX_SEQ + 1)
) (
    input  logic                               sys_clk,
    input  logic                               rst,
    input  logic [NUM_CH-1:0]                  rqst_valid_i,
    input  logic [NUM_CH*SHARE_GROUP_SIZE-1:0] rqst_flag_i,
    output logic [NUM_CH-1:0]                  rqst_ready_o,
    output logic [SHIFT_W-1:0]                 shift_o,
    output logic                               shift_valid_o,
    input  logic                               shift_ready_i,
    output logic                               shift_last_o,
    output logic [CH_W-1:0]                    shift_ch_o,
    output logic [SEQ_W-1:0]                   seq_idx_o,
    output logic                               seq_err_o,
    output logic                               busy_o,
    input  logic [SHARE_GROUP_SIZE-1:0]        cfg_waddr_i,
    input  logic [PAGE_W-1:0]                  cfg_wdata_i,
    input  logic                               cfg_we_i
);
    typedef enum logic [1:0] {IDLE, READ, EMIT, ZERO} state_t;

    state_t                      state;
    logic [PAGE_W-1:0]           mem [PAGE_NUM];
    logic [PAGE_W-1:0]           rdata;
    logic [SHARE_GROUP_SIZE-1:0] addr;
    logic [SHARE_GROUP_SIZE-1:0] flag;
    logic [SEQ_W-1:0]            cnt;
    logic [CH_W-1:0]             ch;
    logic [CH_W-1:0]             rr_ptr;
    logic [CH_W-1:0]             gnt_idx;
    logic [CH_W-1:0]             cand;
    logic                        gnt_any;
    logic                        is_gtr;
    logic                        at_max;
    logic                        last;
    logic [DELTA_W-1:0]          delta;

    always_ff @(posedge sys_clk)
        if (cfg_we_i) mem[cfg_waddr_i] <= cfg_wdata_i;

    // Lowest offset from rr_ptr wins, so scan offsets from high to low.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand = CH_W'((int'(rr_ptr) + i) % NUM_CH);
            if (rqst_valid_i[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign flag   = rqst_flag_i[int'(gnt_idx)*SHARE_GROUP_SIZE +: SHARE_GROUP_SIZE];
    assign is_gtr = rdata[0];
    assign delta  = rdata[DELTA_W:1];
    assign at_max = cnt == SEQ_W'(MAX_SEQ - 1);
    assign last   = !is_gtr || at_max;

    assign rqst_ready_o  = (state == IDLE && gnt_any && !rst) ? NUM_CH'(1) << gnt_idx : '0;
    assign shift_valid_o = state == EMIT || state == ZERO;
    assign shift_o       = state == EMIT ? rdata[PAGE_W-1 -: SHIFT_W] : '0;
    assign shift_last_o  = state == ZERO || (state == EMIT && last);
    assign shift_ch_o    = ch;
    assign seq_idx_o     = cnt;
    assign seq_err_o     = state == EMIT && shift_ready_i && is_gtr && at_max;
    assign busy_o        = state != IDLE;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            addr   <= '0;
            cnt    <= '0;
            ch     <= '0;
            rdata  <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_any) begin
                    ch     <= gnt_idx;
                    addr   <= flag;
                    cnt    <= '0;
                    rr_ptr <= gnt_idx == CH_W'(NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
                    state  <= flag == '0 ? ZERO : READ;
                end
                READ: begin
                    rdata <= mem[addr];
                    state <= EMIT;
                end
                EMIT: if (shift_ready_i) begin
                    if (last) begin
                        state <= IDLE;
                    end else begin
                        addr  <= SHARE_GROUP_SIZE'(int'(addr) + int'(delta));
                        cnt   <= cnt + 1'b1;
                        state <= READ;
                    end
                end
                default: if (shift_ready_i) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memshare_sched_mc.sv
// tb_memshare_sched_mc: directed and randomized checks of memshare_sched_mc against a
// page-walking reference model with a round-robin arbiter model.
module tb_memshare_sched_mc;
    localparam int NUM_CH   = 4;
    localparam int SGS      = 6;
    localparam int DELTA_W  = 4;
    localparam int MAX_SEQ  = 8;
    localparam int SHIFT_W  = 3;
    localparam int PAGE_W   = SHIFT_W + DELTA_W + 1;
    localparam int PAGE_NUM = 64;

    typedef struct {
        int shift;
        bit last;
        bit err;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_CH-1:0]       rqst_valid = '0;
    logic [NUM_CH*SGS-1:0]   rqst_flag = '0;
    logic [NUM_CH-1:0]       rqst_ready;
    logic [SHIFT_W-1:0]      shift;
    logic                    shift_valid;
    logic                    shift_ready = 1'b0;
    logic                    shift_last;
    logic [1:0]              shift_ch;
    logic [3:0]              seq_idx;
    logic                    seq_err;
    logic                    busy;
    logic [SGS-1:0]          cfg_waddr = '0;
    logic [PAGE_W-1:0]       cfg_wdata = '0;
    logic                    cfg_we = 1'b0;

    int          errors = 0;
    int          checks = 0;
    int          rr = 0;
    int          last_g;
    int          r_shift [PAGE_NUM];
    int          r_delta [PAGE_NUM];
    bit          r_gtr   [PAGE_NUM];
    logic [SGS-1:0] flags [NUM_CH];
    beat_t       exp_q[$];

    memshare_sched_mc #(
        .NUM_CH(NUM_CH), .SHARE_GROUP_SIZE(SGS), .DELTA_W(DELTA_W), .MAX_SEQ(MAX_SEQ)
    ) dut (
        .sys_clk(clk), .rst(rst),
        .rqst_valid_i(rqst_valid), .rqst_flag_i(rqst_flag), .rqst_ready_o(rqst_ready),
        .shift_o(shift), .shift_valid_o(shift_valid), .shift_ready_i(shift_ready),
        .shift_last_o(shift_last), .shift_ch_o(shift_ch), .seq_idx_o(seq_idx),
        .seq_err_o(seq_err), .busy_o(busy),
        .cfg_waddr_i(cfg_waddr), .cfg_wdata_i(cfg_wdata), .cfg_we_i(cfg_we)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(string tag);
        chk({tag, "_ready"}, rqst_ready, 0);
        chk({tag, "_valid"}, shift_valid, 0);
        chk({tag, "_shift"}, shift, 0);
        chk({tag, "_last"}, shift_last, 0);
        chk({tag, "_ch"}, shift_ch, 0);
        chk({tag, "_idx"}, seq_idx, 0);
        chk({tag, "_err"}, seq_err, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    function automatic int arb(logic [NUM_CH-1:0] p);
        for (int i = 0; i < NUM_CH; i++)
            if (p[(rr + i) % NUM_CH]) return (rr + i) % NUM_CH;
        return -1;
    endfunction

    // Expected beats: follow the page chain, stop at !isGtr or after MAX_SEQ patterns.
    task automatic build(int flag);
        int p;
        bit fin;
        p = flag;
        exp_q.delete();
        if (flag == 0) begin
            exp_q.push_back('{0, 1'b1, 1'b0});
            return;
        end
        for (int k = 0; k < MAX_SEQ; k++) begin
            fin = !r_gtr[p] || k == MAX_SEQ - 1;
            exp_q.push_back('{r_shift[p], fin, fin && r_gtr[p]});
            if (fin) break;
            p = (p + r_delta[p]) % PAGE_NUM;
        end
    endtask

    task automatic cfg_write(int a, int s, int d, bit g);
        cfg_we = 1'b1;
        cfg_waddr = SGS'(a);
        cfg_wdata = {SHIFT_W'(s), DELTA_W'(d), g};
        @(negedge clk);
        cfg_we = 1'b0;
        r_shift[a] = s;
        r_delta[a] = d;
        r_gtr[a] = g;
    endtask

    // Starts and ends at a negedge with the DUT in IDLE.
    task automatic run_seq(logic [NUM_CH-1:0] pend, int hold, bit wr, int stall);
        int g, n, ws, wd;
        bit wg, acc;
        rqst_valid = pend;
        for (int c = 0; c < NUM_CH; c++) rqst_flag[c*SGS +: SGS] = flags[c];
        #1;
        g = arb(pend);
        last_g = g;
        chk("grant", rqst_ready, 1 << g);
        rr = (g + 1) % NUM_CH;
        build(int'(flags[g]));
        @(negedge clk);
        rqst_valid = pend & ~(NUM_CH'(1) << g);
        rqst_flag[g*SGS +: SGS] = SGS'($urandom);
        if (flags[g] != 0) begin
            if (wr) begin
                ws = $urandom_range(0, 7);
                wd = $urandom_range(0, 15);
                wg = 1'b0;
                cfg_we = 1'b1;
                cfg_waddr = flags[g];
                cfg_wdata = {SHIFT_W'(ws), DELTA_W'(wd), wg};
            end
            chk("lat_gap", shift_valid, 0);
            chk("lat_busy", busy, 1);
            @(negedge clk);
            if (wr) begin
                cfg_we = 1'b0;
                r_shift[flags[g]] = ws;
                r_delta[flags[g]] = wd;
                r_gtr[flags[g]] = wg;
            end
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n = 0;
            do begin
                shift_ready = (i == 0 && n < hold) ? 1'b0 : (n >= 20) ? 1'b1 :
                              ($urandom_range(0, 99) >= stall);
                #1;
                chk("beat_valid", shift_valid, 1);
                chk("beat_shift", shift, exp_q[i].shift);
                chk("beat_last", shift_last, exp_q[i].last);
                chk("beat_ch", shift_ch, g);
                chk("beat_idx", seq_idx, i);
                chk("beat_err", seq_err, shift_ready && exp_q[i].err);
                chk("beat_nogrant", rqst_ready, 0);
                acc = shift_ready;
                n++;
                @(negedge clk);
            end while (!acc);
            shift_ready = 1'b0;
            if (!exp_q[i].last) begin
                chk("beat_gap", shift_valid, 0);
                @(negedge clk);
            end
        end
        chk("end_idle", busy, 0);
        chk("end_valid", shift_valid, 0);
    endtask

    initial begin
        logic [NUM_CH-1:0] pend;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("post_reset");

        // Two-page chain 5 -> 7.
        cfg_write(5, 3, 2, 1'b1);
        cfg_write(7, 1, 0, 1'b0);
        flags[0] = 6'd5;
        run_seq(4'b0001, 0, 1'b0, 0);

        // Reset during the second beat of a chain on ch2.
        rqst_valid = 4'b0100;
        rqst_flag[2*SGS +: SGS] = 6'd5;
        #1 chk("rst_grant", rqst_ready, 4'b0100);
        @(negedge clk);
        rqst_valid = '0;
        @(negedge clk);
        shift_ready = 1'b1;
        #1 chk("rst_beat0", shift, 3);
        @(negedge clk);
        shift_ready = 1'b0;
        @(negedge clk);
        #1 chk("rst_beat1_valid", shift_valid, 1);
        chk("rst_beat1_shift", shift, 1);
        rqst_valid = '1;
        rst = 1'b1;
        #1 chk_quiet("mid_reset");
        @(negedge clk);
        chk_quiet("mid_reset_hold");
        rst = 1'b0;
        rqst_valid = '0;
        rr = 0;

        // All channels at once, single-page chains.
        cfg_write(8, 1, 0, 1'b0);
        cfg_write(9, 2, 0, 1'b0);
        cfg_write(10, 3, 0, 1'b0);
        cfg_write(11, 4, 0, 1'b0);
        for (int c = 0; c < NUM_CH; c++) flags[c] = SGS'(8 + c);
        pend = '1;
        repeat (NUM_CH) begin
            run_seq(pend, 0, 1'b0, 20);
            pend[last_g] = 1'b0;
        end

        // Self-loop truncated at MAX_SEQ.
        cfg_write(20, 2, 0, 1'b1);
        flags[0] = 6'd20;
        run_seq(4'b0001, 0, 1'b0, 0);

        // Zero flag, then address wrap 63 + 3 -> 2.
        flags[1] = '0;
        run_seq(4'b0010, 0, 1'b0, 0);
        cfg_write(63, 4, 3, 1'b1);
        cfg_write(2, 5, 0, 1'b0);
        flags[2] = 6'd63;
        run_seq(4'b0100, 0, 1'b0, 0);

        // Five-cycle stall on the first beat plus a same-cycle write during READ.
        cfg_write(10, 2, 1, 1'b1);
        cfg_write(11, 5, 0, 1'b0);
        flags[3] = 6'd10;
        run_seq(4'b1000, 5, 1'b1, 0);
        cfg_write(10, 2, 1, 1'b1);
        run_seq(4'b1000, 0, 1'b0, 0);

        // Random pages and random request patterns.
        for (int a = 0; a < PAGE_NUM; a++)
            cfg_write(a, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 9) < 7);
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < NUM_CH; c++)
                flags[c] = ($urandom_range(0, 7) == 0) ? '0 : SGS'($urandom);
            run_seq(NUM_CH'($urandom_range(1, 15)), 0, 1'b0, 30);
        end
        rqst_valid = '0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
